// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, key event layout and frame check helper
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
  localparam int EV_W = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_BRK_BIT = 8;
  localparam int EV_EXT_BIT = 9;
  typedef struct packed {
    logic ext;
    logic brk;
    logic [7:0] code;
  } ps2_event_t;
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return !f[0] && f[PS2_FRAME_BITS-1] && (^f[9:1]);
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises PS/2 lines, shifts in 11-bit frames, checks them and runs the mid-frame watchdog
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       timeout
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d, frame;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic byte_valid_q, byte_valid_d, parity_err_q, parity_err_d, timeout_q, timeout_d;
  logic pulse, last, done, expire;
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    pulse = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    frame = {data_sync_q[SYNC_STAGES-1], shift_q[PS2_FRAME_BITS-1:1]};
    last = bit_cnt_q == 4'(PS2_FRAME_BITS - 1);
    expire = !pulse && bit_cnt_q != 4'd0 && wd_q == WD_W'(TIMEOUT_CYCLES - 1);
    done = pulse && last;
    shift_d = pulse ? frame : shift_q;
    bit_cnt_d = pulse ? (last ? 4'd0 : bit_cnt_q + 4'd1) : (expire ? 4'd0 : bit_cnt_q);
    wd_d = (pulse || expire || bit_cnt_q == 4'd0) ? '0 : wd_q + 1'b1;
    rx_byte_d = done ? frame[8:1] : rx_byte_q;
    byte_valid_d = done && frame_ok(frame);
    parity_err_d = done && !frame_ok(frame);
    timeout_d = expire;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= '0;
      data_sync_q <= '0;
      clk_prev_q <= 1'b0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      wd_q <= '0;
      rx_byte_q <= '0;
      byte_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q <= clk_prev_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wd_q <= wd_d;
      rx_byte_q <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      parity_err_q <= parity_err_d;
      timeout_q <= timeout_d;
    end
  end
  assign rx_byte = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign parity_err = parity_err_q;
  assign timeout = timeout_q;
endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_keyboard_rx_fifo: decodes E0/F0-prefixed PS/2 bytes into key events buffered in a first-word fall-through FIFO
module ps2_keyboard_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              break_cnt,
  output logic                          err_parity,
  output logic                          err_timeout,
  output logic                          err_overflow,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] rx_byte;
  logic byte_valid, parity_err, timeout;
  ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .parity_err(parity_err), .timeout(timeout)
  );
  ps2_event_t mem_q [FIFO_DEPTH];
  ps2_event_t mem_d [FIFO_DEPTH];
  ps2_event_t ev, head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [CNT_W-1:0] break_cnt_q, break_cnt_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic err_parity_q, err_parity_d, err_timeout_q, err_timeout_d, err_overflow_q, err_overflow_d;
  logic emit, pop, full, push_ok, overflow;
  always_comb begin
    emit = byte_valid && rx_byte != PS2_EXT && rx_byte != PS2_BRK;
    ev = '{ext: ext_q, brk: brk_q, code: rx_byte};
    ext_d = emit ? 1'b0 : (byte_valid && rx_byte == PS2_EXT) ? 1'b1 : ext_q;
    brk_d = emit ? 1'b0 : (byte_valid && rx_byte == PS2_BRK) ? 1'b1 : brk_q;
    break_cnt_d = break_cnt_q + CNT_W'(emit && brk_q);
    pop = level_q != '0 && key_ready;
    full = level_q == (AW+1)'(FIFO_DEPTH);
    push_ok = emit && (!full || pop);
    overflow = emit && full && !pop;
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = ev;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    err_parity_d = parity_err | (err_parity_q & ~err_clr);
    err_timeout_d = timeout | (err_timeout_q & ~err_clr);
    err_overflow_d = overflow | (err_overflow_q & ~err_clr);
    head = mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      break_cnt_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      err_parity_q <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      break_cnt_q <= break_cnt_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      err_parity_q <= err_parity_d;
      err_timeout_q <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end
  assign key_valid = level_q != '0;
  assign key_code = head.code;
  assign key_ext = head.ext;
  assign key_break = head.brk;
  assign fifo_level = level_q;
  assign break_cnt = break_cnt_q;
  assign err_parity = err_parity_q;
  assign err_timeout = err_timeout_q;
  assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_ps2_keyboard_rx_fifo.sv
// tb_ps2_keyboard_rx_fifo: directed PS/2 frames with a queue scoreboard checked by a separate pop monitor
module tb_ps2_keyboard_rx_fifo;
  localparam int TO = 200;
  logic clk = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, key_ready = 1'b0, err_clr = 1'b0;
  logic key_valid, key_ext, key_break, err_parity, err_timeout, err_overflow;
  logic [7:0] key_code, break_cnt;
  logic [3:0] fifo_level;
  logic [9:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  ps2_keyboard_rx_fifo #(.FIFO_DEPTH(8), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .fifo_level(fifo_level), .break_cnt(break_cnt),
    .err_parity(err_parity), .err_timeout(err_timeout), .err_overflow(err_overflow), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (resetn && key_valid && key_ready) begin
      if (exp_q.size() == 0) check("unexpected_event", {key_ext, key_break, key_code}, 10'h3FF);
      else check("event", {key_ext, key_break, key_code}, exp_q.pop_front());
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(8);
      ps2_clk = 1'b0;
      tick(8);
      ps2_clk = 1'b1;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits({1'b1, ~^b ^ bad, b, 1'b0}, 11);
    tick(20);
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || key_valid); i++) tick(1);
    check("drain_queue", exp_q.size(), 0);
    check("drain_level", fifo_level, 0);
  endtask
  logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  initial begin
    tick(3);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_level", fifo_level, 0);
    check("rst_errs", {err_parity, err_timeout, err_overflow}, 0);
    resetn = 1'b1;
    tick(5);
    key_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h1C});
    send_byte(8'h1C, 0);
    wait_drain();
    exp_q.push_back({2'b01, 8'h1C});
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    wait_drain();
    check("break_cnt1", break_cnt, 1);
    exp_q.push_back({2'b11, 8'h75});
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    wait_drain();
    check("break_cnt2", break_cnt, 2);
    send_byte(8'h1C, 1);
    wait_drain();
    check("err_parity_set", err_parity, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_parity_clr", err_parity, 0);
    send_bits(11'h038, 4);
    tick(TO + 20);
    check("err_timeout", err_timeout, 1);
    check("no_parity_after_to", err_parity, 0);
    exp_q.push_back({2'b00, 8'h29});
    send_byte(8'h29, 0);
    wait_drain();
    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({2'b00, codes[i]});
      send_byte(codes[i], 0);
    end
    check("full_level", fifo_level, 8);
    check("err_overflow", err_overflow, 1);
    check("full_head", key_code, 8'h15);
    key_ready = 1'b1;
    wait_drain();
    send_bits({1'b1, ~^8'h5A, 8'h5A, 1'b0}, 5);
    resetn = 1'b0;
    tick(3);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_cnt", break_cnt, 0);
    check("mid_rst_errs", {err_parity, err_timeout, err_overflow}, 0);
    resetn = 1'b1;
    tick(5);
    check("post_rst_level", fifo_level, 0);
    exp_q.push_back({2'b00, 8'h5A});
    send_byte(8'h5A, 0);
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
